uart_cmd_decoder: RTL and testbench

Parametrised ASCII command decoder between the Bluetooth UART controller's RX/TX FIFO ports and a bank of `NUM_OUT` registered output bits (LEDR and GPIO drivers). It pops bytes from the RX FIFO and optionally echoes them. It parses two-byte set/clear/toggle commands and one-byte global and query commands, and answers every command with an ASCII status byte. Backpressure from the TX FIFO stalls it without dropping data.

---
 rtl/uart_cmd_pkg.sv | 47 ++++
 rtl/uart_cmd_hex.sv | 27 ++
 rtl/uart_cmd_decoder.sv | 180 ++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART ASCII command decoder.
// Optional echo state is present only when UART_CMD_ECHO_EN is defined.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
`ifdef UART_CMD_ECHO_EN
        ST_ECHO,
`endif
        ST_PARSE,
        ST_RESP,
        ST_QUERY
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_SET,
        PEND_CLR,
        PEND_TGL
    } pend_t;

    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_T     = 8'h54;
    localparam logic [7:0] ASCII_Z     = 8'h5A;
    localparam logic [7:0] ASCII_F     = 8'h46;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_K     = 8'h4B;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    function automatic int hex_digits(input int n);
        return (n + 3) / 4;
    endfunction

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction

    function automatic logic is_space(input logic [7:0] c);
        return (c == ASCII_SP) || (c == ASCII_CR) || (c == ASCII_LF);
    endfunction

endpackage

// File: rtl/uart_cmd_hex.sv
// Hex helpers: ASCII hex digit to nibble (with valid flag) and nibble to
// uppercase ASCII. Purely combinational.
module uart_cmd_hex (
    input  logic [7:0] ascii_in,
    output logic [3:0] nib_out,
    output logic       nib_valid,
    input  logic [3:0] nib_in,
    output logic [7:0] ascii_out
);

    always_comb begin
        nib_out   = 4'h0;
        nib_valid = 1'b0;
        if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
            nib_out   = ascii_in[3:0];
            nib_valid = 1'b1;
        end else if ((ascii_in >= 8'h41 && ascii_in <= 8'h46) ||
                     (ascii_in >= 8'h61 && ascii_in <= 8'h66)) begin
            // Low nibble of 'A'/'a' is 1, so add 9 to reach 10.
            nib_out   = ascii_in[3:0] + 4'd9;
            nib_valid = 1'b1;
        end
    end

    assign ascii_out = (nib_in < 4'd10) ? {4'h3, nib_in} : (8'h37 + {4'h0, nib_in});

endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder between RX/TX FIFOs and NUM_OUT output bits.
// Define UART_CMD_ECHO_EN to echo every popped byte before parsing it.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int                 NUM_OUT     = 10,
    parameter logic [NUM_OUT-1:0] RESET_VALUE = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rdempty,
    input  logic [7:0]         readdata,
    output logic               read,
    input  logic               wrfull,
    output logic               write,
    output logic [7:0]         writedata,
    output logic [NUM_OUT-1:0] out,
    output logic               cmd_done
);

    localparam int         HEX_DIGITS = hex_digits(NUM_OUT);
    localparam logic [1:0] TOP_DIGIT  = 2'(HEX_DIGITS - 1);

    state_t             state_reg;
    pend_t              pend_reg;
    logic [7:0]         rx_byte_reg;
    logic [7:0]         writedata_reg;
    logic               tx_valid_reg;
    logic               read_reg;
    logic [NUM_OUT-1:0] out_reg;
    logic [1:0]         digit_idx_reg;

    logic [3:0]         arg_nib;
    logic               arg_valid;
    logic               arg_in_range;
    logic [1:0]         digit_sel;
    logic [15:0]        out_pad;
    logic [7:0]         digit_ascii;
    logic [7:0]         rx_upper;
    logic [NUM_OUT-1:0] bit_mask;

    // In PARSE the first (MSB) digit is staged; in QUERY the next lower one.
    assign digit_sel = (state_reg == ST_QUERY) ? digit_idx_reg - 2'd1 : TOP_DIGIT;
    assign out_pad   = 16'(out_reg);
    assign rx_upper  = to_upper(rx_byte_reg);

    uart_cmd_hex u_hex (
        .ascii_in  (rx_byte_reg),
        .nib_out   (arg_nib),
        .nib_valid (arg_valid),
        .nib_in    (out_pad[{digit_sel, 2'b00} +: 4]),
        .ascii_out (digit_ascii)
    );

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_mask
            assign bit_mask[gi] = (arg_nib == 4'(gi));
        end
    endgenerate

    assign arg_in_range = arg_valid && (int'(arg_nib) < NUM_OUT);

    // TX handshake is gated by wrfull so a stalled byte is never pushed.
    assign write     = tx_valid_reg && !wrfull;
    assign writedata = writedata_reg;
    assign read      = read_reg;
    assign out       = out_reg;
    assign cmd_done  = (state_reg == ST_RESP) && write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            pend_reg      <= PEND_NONE;
            rx_byte_reg   <= 8'h00;
            writedata_reg <= 8'h00;
            tx_valid_reg  <= 1'b0;
            read_reg      <= 1'b0;
            out_reg       <= RESET_VALUE;
            digit_idx_reg <= 2'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!rdempty) begin
                        read_reg  <= 1'b1;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    read_reg    <= 1'b0;
                    rx_byte_reg <= readdata;
`ifdef UART_CMD_ECHO_EN
                    writedata_reg <= readdata;
                    tx_valid_reg  <= 1'b1;
                    state_reg     <= ST_ECHO;
`else
                    state_reg     <= ST_PARSE;
`endif
                end
`ifdef UART_CMD_ECHO_EN
                ST_ECHO: begin
                    if (!wrfull) begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= ST_PARSE;
                    end
                end
`endif
                ST_PARSE: begin
                    if (is_space(rx_byte_reg)) begin
                        state_reg <= ST_IDLE;
                    end else if (pend_reg != PEND_NONE) begin
                        pend_reg     <= PEND_NONE;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= ST_RESP;
                        if (arg_in_range) begin
                            writedata_reg <= ASCII_K;
                            case (pend_reg)
                                PEND_SET: out_reg <= out_reg | bit_mask;
                                PEND_CLR: out_reg <= out_reg & ~bit_mask;
                                default:  out_reg <= out_reg ^ bit_mask;
                            endcase
                        end else begin
                            writedata_reg <= ASCII_E;
                        end
                    end else begin
                        case (rx_upper)
                            ASCII_S: begin pend_reg <= PEND_SET; state_reg <= ST_IDLE; end
                            ASCII_C: begin pend_reg <= PEND_CLR; state_reg <= ST_IDLE; end
                            ASCII_T: begin pend_reg <= PEND_TGL; state_reg <= ST_IDLE; end
                            ASCII_Z: begin
                                out_reg       <= '0;
                                writedata_reg <= ASCII_K;
                                tx_valid_reg  <= 1'b1;
                                state_reg     <= ST_RESP;
                            end
                            ASCII_F: begin
                                out_reg       <= '1;
                                writedata_reg <= ASCII_K;
                                tx_valid_reg  <= 1'b1;
                                state_reg     <= ST_RESP;
                            end
                            ASCII_QMARK: begin
                                digit_idx_reg <= TOP_DIGIT;
                                writedata_reg <= digit_ascii;
                                tx_valid_reg  <= 1'b1;
                                state_reg     <= ST_QUERY;
                            end
                            default: begin
                                writedata_reg <= ASCII_E;
                                tx_valid_reg  <= 1'b1;
                                state_reg     <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_RESP: begin
                    if (!wrfull) begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end
                end
                ST_QUERY: begin
                    if (!wrfull) begin
                        if (digit_idx_reg == 2'd0) begin
                            writedata_reg <= ASCII_K;
                            state_reg     <= ST_RESP;
                        end else begin
                            digit_idx_reg <= digit_idx_reg - 2'd1;
                            writedata_reg <= digit_ascii;
                        end
                    end
                end
                default: begin
                    tx_valid_reg <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: vector table, hand sequences for
// stall/reset/latency, and random byte streams against a reference model.
module tb_uart_cmd_decoder;

    localparam int                 NUM_OUT     = 10;
    localparam logic [NUM_OUT-1:0] RESET_VALUE = '0;
    localparam int                 HEXD        = (NUM_OUT + 3) / 4;
`ifdef UART_CMD_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    typedef byte unsigned bq_t[$];

    typedef struct {
        string              cmd;
        logic [NUM_OUT-1:0] exp_out;
        string              exp_resp;
        int                 exp_done;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               rdempty = 1'b1;
    logic [7:0]         readdata = 8'h00;
    logic               read;
    logic               wrfull = 1'b0;
    logic               write;
    logic [7:0]         writedata;
    logic [NUM_OUT-1:0] out;
    logic               cmd_done;

    int checks = 0;
    int errors = 0;

    uart_cmd_decoder #(.NUM_OUT(NUM_OUT), .RESET_VALUE(RESET_VALUE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rdempty   (rdempty),
        .readdata  (readdata),
        .read      (read),
        .wrfull    (wrfull),
        .write     (write),
        .writedata (writedata),
        .out       (out),
        .cmd_done  (cmd_done)
    );

    always #5 clk = ~clk;

    // Show-ahead RX FIFO model: a byte is popped one cycle after its read pulse.
    byte unsigned rx_q[$];
    bit pop_flag = 1'b0;
    int read_cnt = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            pop_flag = 1'b0;
        end else begin
            if (pop_flag && rx_q.size() > 0) void'(rx_q.pop_front());
            pop_flag = read;
            if (read) read_cnt++;
        end
        rdempty  = (rx_q.size() == 0);
        readdata = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    end

    // TX FIFO sink.
    byte unsigned tx_got[$];
    int done_cnt = 0;
    always @(negedge clk) begin
        if (write) begin
            tx_got.push_back(writedata);
            checks++;
            if (wrfull) begin
                errors++;
                $display("FAIL write_while_full got write=1 wrfull=1 required write=0");
            end
        end
        if (cmd_done) done_cnt++;
    end

    bit force_full = 1'b0;
    bit rand_stall = 1'b0;
    always @(posedge clk) begin
        #2;
        wrfull = force_full | (rand_stall && ($urandom_range(0, 3) == 0));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [NUM_OUT-1:0] m_out;
    int                 m_pend;   // 0 none, 1 set, 2 clear, 3 toggle
    byte unsigned       exp_q[$];
    int                 exp_done;

    function automatic int hexval(input byte unsigned b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        return -1;
    endfunction

    task automatic model_byte(input byte unsigned b);
        byte unsigned u;
        int v;
        string digits;
        digits = "0123456789ABCDEF";
        if (ECHO) exp_q.push_back(b);
        if (b == 8'h20 || b == 8'h0D || b == 8'h0A) return;
        u = (b >= "a" && b <= "z") ? b - 8'd32 : b;
        if (m_pend != 0) begin
            v = hexval(b);
            if (v >= 0 && v < NUM_OUT) begin
                if (m_pend == 1) m_out = m_out | (NUM_OUT'(1) << v);
                else if (m_pend == 2) m_out = m_out & ~(NUM_OUT'(1) << v);
                else m_out = m_out ^ (NUM_OUT'(1) << v);
                exp_q.push_back("K");
            end else begin
                exp_q.push_back("E");
            end
            m_pend = 0;
            exp_done++;
        end else if (u == "S") m_pend = 1;
        else if (u == "C") m_pend = 2;
        else if (u == "T") m_pend = 3;
        else if (u == "Z") begin m_out = '0; exp_q.push_back("K"); exp_done++; end
        else if (u == "F") begin m_out = '1; exp_q.push_back("K"); exp_done++; end
        else if (u == "?") begin
            for (int d = HEXD - 1; d >= 0; d--)
                exp_q.push_back(digits[(int'(m_out) >> (4 * d)) & 15]);
            exp_q.push_back("K");
            exp_done++;
        end else begin
            exp_q.push_back("E");
            exp_done++;
        end
    endtask

    // ---------------- helpers ----------------
    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic check_tx(input string name, input int start, input bq_t exp);
        string gs, es;
        bit ok;
        int n;
        gs = "";
        es = "";
        n  = tx_got.size() - start;
        ok = (n == exp.size());
        for (int i = 0; i < n && i < 60; i++) gs = {gs, $sformatf("%02h", tx_got[start + i])};
        for (int i = 0; i < exp.size(); i++) begin
            if (i < 60) es = {es, $sformatf("%02h", exp[i])};
            if (ok && tx_got[start + i] != exp[i]) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s tx got=%s required=%s", name, gs, es);
        end
    endtask

    task automatic send_byte(input byte unsigned b);
        @(posedge clk);
        #1;
        rx_q.push_back(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (rx_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rx_drain_remaining", rx_q.size(), 0);
        repeat (60) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        rx_q.delete();
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    vec_t vecs[$];
    task automatic add_vec(input string c, input logic [NUM_OUT-1:0] o, input string r, input int d);
        vec_t v;
        v.cmd = c; v.exp_out = o; v.exp_resp = r; v.exp_done = d;
        vecs.push_back(v);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t0, d0, r0, kr, kd, bad, n, len;
        logic [7:0] held;
        string pool;
        byte unsigned b;

        add_vec("S3",     10'h008, "K",    1);
        add_vec("c3",     10'h000, "K",    1);
        add_vec("T3",     10'h008, "K",    1);
        add_vec("t9",     10'h208, "K",    1);
        add_vec("C3",     10'h200, "K",    1);
        add_vec("SA",     10'h200, "E",    1);
        add_vec("Sx",     10'h200, "E",    1);
        add_vec("Q",      10'h200, "E",    1);
        add_vec("F",      10'h3FF, "K",    1);
        add_vec("c0",     10'h3FE, "K",    1);
        add_vec("?",      10'h3FE, "3FEK", 1);
        add_vec("Z",      10'h000, "K",    1);
        add_vec("s\r5",   10'h020, "K",    1);
        add_vec("Tf",     10'h020, "E",    1);
        add_vec(" t\n2",  10'h024, "K",    1);
        add_vec("S?",     10'h024, "E",    1);
        add_vec("Z",      10'h000, "K",    1);
        add_vec("S0",     10'h001, "K",    1);
        add_vec("S2",     10'h005, "K",    1);
        add_vec("S5",     10'h025, "K",    1);
        add_vec("S7",     10'h0A5, "K",    1);
        add_vec("s9",     10'h2A5, "K",    1);
        add_vec("?",      10'h2A5, "2A5K", 1);
        add_vec("x",      10'h2A5, "E",    1);
        add_vec("\n",     10'h2A5, "",     0);

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        #1;
        check("reset_out", 32'(out), 32'(RESET_VALUE));
        check("reset_read", 32'(read), 0);
        check("reset_write", 32'(write), 0);
        check("reset_writedata", 32'(writedata), 0);
        check("reset_cmd_done", 32'(cmd_done), 0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < vecs.size(); r++) begin
            t0 = tx_got.size();
            d0 = done_cnt;
            r0 = read_cnt;
            send_str(vecs[r].cmd);
            settle();
            check_tx($sformatf("row%0d", r), t0,
                     str2q(ECHO ? {vecs[r].cmd, vecs[r].exp_resp} : vecs[r].exp_resp));
            check($sformatf("row%0d_out", r), 32'(out), 32'(vecs[r].exp_out));
            check($sformatf("row%0d_done", r), done_cnt - d0, vecs[r].exp_done);
            check($sformatf("row%0d_reads", r), read_cnt - r0, vecs[r].cmd.len());
            $display("row %0d: %0d bytes in, %0d bytes out, out=%h", r, vecs[r].cmd.len(),
                     tx_got.size() - t0, out);
        end

        // TX backpressure: hold wrfull for 20 cycles with a byte waiting.
        force_full = 1'b1;
        t0 = tx_got.size();
        send_str("S1");
        repeat (12) @(negedge clk);
        #1;
        held = writedata;
        bad  = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (write || writedata !== held) bad++;
        end
        check("stall_hold_violations", bad, 0);
        force_full = 1'b0;
        settle();
        check_tx("stall_release", t0, str2q(ECHO ? "S1K" : "K"));
        check("stall_out", 32'(out), 32'h2A7);
        $display("stall: %0d bytes out after release, out=%h", tx_got.size() - t0, out);

        // Reset in the middle of a query.
        t0 = tx_got.size();
        send_str("?");
        n = 0;
        while (tx_got.size() <= t0 + (ECHO ? 1 : 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("query_first_digit_timeout", 32'(n < 50), 1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        check("midreset_out", 32'(out), 32'(RESET_VALUE));
        check("midreset_write", 32'(write), 0);
        check("midreset_writedata", 32'(writedata), 0);
        check("midreset_cmd_done", 32'(cmd_done), 0);
        t0 = tx_got.size();
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("midreset_no_tx", tx_got.size() - t0, 0);
        t0 = tx_got.size();
        send_str("F");
        settle();
        check_tx("after_reset_F", t0, str2q(ECHO ? "FK" : "K"));
        check("after_reset_out", 32'(out), 32'h3FF);
        $display("midreset: out=%h after F", out);

        // Latency from rdempty falling to the response push.
        t0 = tx_got.size();
        r0 = read_cnt;
        kr = -1;
        kd = -1;
        send_byte("Z");
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            #1;
            if (!rdempty && kr < 0) kr = k;
            if (cmd_done && kd < 0) kd = k;
        end
        check("latency_cycles", kd - kr, ECHO ? 4 : 3);
        check("latency_out", 32'(out), 0);
        check("latency_reads", read_cnt - r0, 1);
        check_tx("latency_tx", t0, str2q(ECHO ? "ZK" : "K"));
        $display("latency: rdempty seen at %0d, cmd_done at %0d", kr, kd);

        // Random byte streams with random TX stalls against the model.
        do_reset();
        m_out  = RESET_VALUE;
        m_pend = 0;
        rand_stall = 1'b1;
        pool = "SCTZF?stcz0123456789ABCDEFabcdefxQ \r\n";
        for (int bt = 0; bt < 50; bt++) begin
            exp_q.delete();
            exp_done = 0;
            t0  = tx_got.size();
            d0  = done_cnt;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                b = pool[$urandom_range(0, pool.len() - 1)];
                model_byte(b);
                send_byte(b);
            end
            settle();
            check_tx($sformatf("rand%0d", bt), t0, exp_q);
            check($sformatf("rand%0d_out", bt), 32'(out), 32'(m_out));
            check($sformatf("rand%0d_done", bt), done_cnt - d0, exp_done);
            $display("rand batch %0d: %0d bytes in, %0d bytes out, out=%h", bt, len,
                     tx_got.size() - t0, out);
        end
        rand_stall = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
